// File: rtl/lsu_mem.sv
// lsu_mem: single-outstanding load/store unit between exe_mem and a word-wide data bus.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses instead of aligning them down).
module lsu_mem (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  mem_op_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [31:0] reg_wdata_i,
  output logic [4:0]  reg_waddr_o,
  output logic        reg_we_o,
  output logic [31:0] reg_wdata_o,
  output logic        stall_req_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  be_q, be_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        we_q, we_d;
  logic        rwe_q, rwe_d;
  logic        ok_q, ok_d;

  logic        is_byte, is_half, is_word, op_valid;
  logic [1:0]  off;
  logic [31:0] lane;
  logic [7:0]  cnt_inc;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  // Request decode; the lane offset drops address bits below the access size.
  always_comb begin
    is_byte  = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
    is_half  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
    is_word  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    op_valid = is_byte || is_half || is_word;
    off      = is_byte ? mem_addr_i[1:0] : (is_half ? {mem_addr_i[1], 1'b0} : 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
`endif
  end

  assign lane    = bus_rdata_i >> {off_q, 3'b000};
  assign cnt_inc = cnt_q + 8'd1;

  assign bus_addr_o  = addr_q;
  assign bus_we_o    = we_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    result_d    = result_q;
    be_d        = be_q;
    waddr_d     = waddr_q;
    we_d        = we_q;
    rwe_d       = rwe_q;
    ok_d        = ok_q;
    stall_req_o = 1'b0;
    bus_req_o   = 1'b0;
    bus_err_o   = 1'b0;
    reg_waddr_o = 5'd0;
    reg_we_o    = 1'b0;
    reg_wdata_o = 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_o  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // IDLE outputs follow the inputs combinationally, so they are gated by reset.
        if (rst_n_i) begin
          if (!op_valid) begin
            reg_waddr_o = reg_waddr_i;
            reg_we_o    = reg_we_i;
            reg_wdata_o = reg_wdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
          end else if (misaligned) begin
            misalign_o  = 1'b1;
`endif
          end else begin
            stall_req_o = 1'b1;
            op_d        = mem_op_i;
            off_d       = off;
            addr_d      = {mem_addr_i[31:2], 2'b00};
            we_d        = mem_we_i;
            waddr_d     = reg_waddr_i;
            rwe_d       = reg_we_i;
            ok_d        = 1'b0;
            result_d    = 32'd0;
            cnt_d       = 8'd0;
            be_d        = is_byte ? (4'b0001 << off) : (is_half ? (4'b0011 << off) : 4'b1111);
            wdata_d     = !mem_we_i ? 32'd0 :
                          is_byte   ? {4{mem_data_i[7:0]}} :
                          is_half   ? {2{mem_data_i[15:0]}} : mem_data_i;
            state_d     = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        bus_req_o   = 1'b1;
        stall_req_o = 1'b1;
        cnt_d       = cnt_inc;
        if (bus_ack_i) begin
          ok_d    = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_DONE;
          case (op_q)
            OP_LB:   result_d = {{24{lane[7]}}, lane[7:0]};
            OP_LH:   result_d = {{16{lane[15]}}, lane[15:0]};
            OP_LBU:  result_d = {24'd0, lane[7:0]};
            OP_LHU:  result_d = {16'd0, lane[15:0]};
            default: result_d = lane;
          endcase
        end else if (cnt_inc == 8'hFF) begin
          // Error flags in the 255th unacknowledged WAIT cycle; the request drops in DONE.
          bus_err_o = 1'b1;
          ok_d      = 1'b0;
          cnt_d     = 8'd0;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        reg_waddr_o = we_q ? 5'd0 : waddr_q;
        reg_we_o    = ok_q && rwe_q && !we_q;
        reg_wdata_o = result_q;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      op_q     <= 4'd0;
      off_q    <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      result_q <= 32'd0;
      be_q     <= 4'd0;
      waddr_q  <= 5'd0;
      we_q     <= 1'b0;
      rwe_q    <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      be_q     <= be_d;
      waddr_q  <= waddr_d;
      we_q     <= we_d;
      rwe_q    <= rwe_d;
      ok_q     <= ok_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: table-driven check of lsu_mem transactions plus hand-written timeout/reset/NOP sequences.
// Honours LSU_MISALIGN_TRAP_EN to match the build of the design.
module tb_lsu_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mem_op;
  logic        mem_we;
  logic [31:0] mem_addr, mem_data;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stall_req, bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .mem_op_i    (mem_op),
    .mem_we_i    (mem_we),
    .mem_addr_i  (mem_addr),
    .mem_data_i  (mem_data),
    .reg_waddr_i (reg_waddr_i),
    .reg_we_i    (reg_we_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_waddr_o (reg_waddr_o),
    .reg_we_o    (reg_we_o),
    .reg_wdata_o (reg_wdata_o),
    .stall_req_o (stall_req),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_be_o    (bus_be),
    .bus_ack_i   (bus_ack),
    .bus_rdata_i (bus_rdata),
    .bus_err_o   (bus_err)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_o  (misalign)
`endif
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  waddr;
    logic        rwe;
    int          dly;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_bwdata;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                              input logic [4:0] waddr, input logic rwe, input int dly,
                              input logic [31:0] rdata, input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_bwdata, input logic e_we, input logic [4:0] e_waddr,
                              input logic [31:0] e_wdata);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.waddr = waddr; v.rwe = rwe; v.dly = dly;
    v.rdata = rdata; v.e_addr = e_addr; v.e_be = e_be; v.e_bwdata = e_bwdata;
    v.e_we = e_we; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_op = 4'd0; mem_we = 1'b0; mem_addr = 32'd0; mem_data = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'h0BAD_0BAD;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] waddr, input logic rwe);
    mem_op = op; mem_we = (op >= 4'd6) && (op <= 4'd8); mem_addr = addr; mem_data = data;
    reg_waddr_i = waddr; reg_we_i = rwe; reg_wdata_i = 32'h5555_AAAA;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic store;
    store = (v.op >= 4'd6);
    @(posedge clk); #1;
    drive_op(v.op, v.addr, v.data, v.waddr, v.rwe);
    @(negedge clk);
    check("accept_stall", stall_req, 1'b1);
    check("accept_req", bus_req, 1'b0);
    for (int i = 0; i <= v.dly; i++) begin
      @(posedge clk); #1;
      bus_ack   = (i == v.dly);
      bus_rdata = (i == v.dly) ? v.rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      check("wait_req", bus_req, 1'b1);
      check("wait_stall", stall_req, 1'b1);
      check("bus_addr", bus_addr, v.e_addr);
      check("bus_be", bus_be, v.e_be);
      check("bus_we", bus_we, store);
      if (store) check("bus_wdata", bus_wdata, v.e_bwdata);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check("done_stall", stall_req, 1'b0);
    check("done_req", bus_req, 1'b0);
    check("done_reg_we", reg_we_o, v.e_we);
    check("done_waddr", reg_waddr_o, v.e_waddr);
    if (v.e_we) check("done_wdata", reg_wdata_o, v.e_wdata);
    $display("vec %0d op=%0d addr=%h -> bus_addr=%h be=%b reg_we=%b wdata=%h",
             idx, v.op, v.addr, bus_addr, bus_be, reg_we_o, reg_wdata_o);
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    int n;
    int errs;

    vecs.push_back(mk(4'd3, 32'h100, 32'h0, 5'd5, 1'b1, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF));
    vecs.push_back(mk(4'd1, 32'h203, 32'h0, 5'd7, 1'b1, 0, 32'h80FFFF7F, 32'h200, 4'b1000, 32'h0, 1'b1, 5'd7, 32'hFFFFFF80));
    vecs.push_back(mk(4'd4, 32'h203, 32'h0, 5'd8, 1'b1, 2, 32'h80FFFF7F, 32'h200, 4'b1000, 32'h0, 1'b1, 5'd8, 32'h00000080));
    vecs.push_back(mk(4'd2, 32'h202, 32'h0, 5'd9, 1'b1, 1, 32'h80FFFF7F, 32'h200, 4'b1100, 32'h0, 1'b1, 5'd9, 32'hFFFF80FF));
    vecs.push_back(mk(4'd5, 32'h200, 32'h0, 5'd10, 1'b1, 0, 32'h12348765, 32'h200, 4'b0011, 32'h0, 1'b1, 5'd10, 32'h00008765));
    vecs.push_back(mk(4'd1, 32'h200, 32'h0, 5'd11, 1'b1, 0, 32'h80FFFF7F, 32'h200, 4'b0001, 32'h0, 1'b1, 5'd11, 32'h0000007F));
    vecs.push_back(mk(4'd7, 32'h12, 32'h0000ABCD, 5'd12, 1'b1, 0, 32'h0, 32'h10, 4'b1100, 32'hABCDABCD, 1'b0, 5'd0, 32'h0));
    vecs.push_back(mk(4'd6, 32'h31, 32'h000000A5, 5'd13, 1'b1, 1, 32'h0, 32'h30, 4'b0010, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0));
    vecs.push_back(mk(4'd8, 32'h44, 32'h12345678, 5'd14, 1'b1, 0, 32'h0, 32'h44, 4'b1111, 32'h12345678, 1'b0, 5'd0, 32'h0));
    vecs.push_back(mk(4'd3, 32'h48, 32'h0, 5'd15, 1'b0, 0, 32'hCAFEF00D, 32'h48, 4'b1111, 32'h0, 1'b0, 5'd15, 32'h0));
`ifndef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(4'd3, 32'h101, 32'h0, 5'd16, 1'b1, 0, 32'h01020304, 32'h100, 4'b1111, 32'h0, 1'b1, 5'd16, 32'h01020304));
`endif

    // Reset state, with a live writeback request on the inputs.
    rst_n = 1'b0;
    drive_idle();
    reg_waddr_i = 5'd3; reg_we_i = 1'b1; reg_wdata_i = 32'h11112222;
    #12;
    check("rst_reg_we", reg_we_o, 1'b0);
    check("rst_reg_waddr", reg_waddr_o, 5'd0);
    check("rst_reg_wdata", reg_wdata_o, 32'd0);
    check("rst_stall", stall_req, 1'b0);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_be", bus_be, 4'd0);
    check("rst_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // NOP and undefined op pass the writeback through with zero latency.
    reg_waddr_i = 5'd9; reg_we_i = 1'b1; reg_wdata_i = 32'h12345678;
    @(negedge clk);
    check("nop_waddr", reg_waddr_o, 5'd9);
    check("nop_we", reg_we_o, 1'b1);
    check("nop_wdata", reg_wdata_o, 32'h12345678);
    check("nop_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    mem_op = 4'd11; reg_wdata_i = 32'h87654321;
    @(negedge clk);
    check("op11_wdata", reg_wdata_o, 32'h87654321);
    check("op11_stall", stall_req, 1'b0);
    $display("nop passthrough: waddr=%0d we=%b wdata=%h", reg_waddr_o, reg_we_o, reg_wdata_o);
    @(posedge clk); #1;
    drive_idle();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Timeout: no ack; error expected in the 255th WAIT cycle.
    @(posedge clk); #1;
    drive_op(4'd3, 32'h400, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    n = 301;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_err) begin
        n = i;
        break;
      end
    end
    check("timeout_cycle", n, 255);
    @(posedge clk);
    @(negedge clk);
    check("to_done_err", bus_err, 1'b0);
    check("to_done_req", bus_req, 1'b0);
    check("to_done_reg_we", reg_we_o, 1'b0);
    check("to_done_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    reg_we_i = 1'b0;
    @(negedge clk);
    check("to_idle_stall", stall_req, 1'b0);
    check("to_idle_req", bus_req, 1'b0);
    $display("timeout: bus_err after %0d wait cycles", n);

    // Ack coincident with the timeout wins.
    @(posedge clk); #1;
    drive_op(4'd3, 32'h404, 32'h0, 5'd4, 1'b1);
    errs = 0;
    for (int i = 1; i <= 255; i++) begin
      @(posedge clk); #1;
      bus_ack   = (i == 255);
      bus_rdata = 32'h5A5A1234;
      @(negedge clk);
      if (bus_err) errs++;
    end
    check("ack_at_timeout_err", errs, 0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check("ack_at_timeout_we", reg_we_o, 1'b1);
    check("ack_at_timeout_wdata", reg_wdata_o, 32'h5A5A1234);
    $display("ack at timeout: errors=%0d reg_we=%b wdata=%h", errs, reg_we_o, reg_wdata_o);
    @(posedge clk); #1;
    drive_idle();

    // Reset in WAIT abandons the access; a late ack is ignored.
    @(posedge clk); #1;
    drive_op(4'd3, 32'h500, 32'h0, 5'd6, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_wait_req", bus_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_req_now", bus_req, 1'b0);
    check("rw_stall_now", stall_req, 1'b0);
    check("rw_reg_we_now", reg_we_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_idle();
    reg_we_i = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rw_late_req", bus_req, 1'b0);
      check("rw_late_we", reg_we_o, 1'b0);
      check("rw_late_stall", stall_req, 1'b0);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    $display("reset in wait: bus_req=%b reg_we=%b", bus_req, reg_we_o);

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned LW traps in IDLE without touching the bus.
    @(posedge clk); #1;
    drive_op(4'd3, 32'h101, 32'h0, 5'd2, 1'b1);
    @(negedge clk);
    check("mis_pulse", misalign, 1'b1);
    check("mis_stall", stall_req, 1'b0);
    check("mis_req", bus_req, 1'b0);
    check("mis_reg_we", reg_we_o, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("mis_clear", misalign, 1'b0);
    check("mis_req_after", bus_req, 1'b0);
    $display("misaligned LW 0x101: trapped");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
